// File: rtl/gppcu_issue_queue.sv
// In-order issue FIFO feeding the register-scoreboard stall generator; head retires when no hazard.
// Optional macro GPPCU_ISSUE_BYPASS_EN: empty-queue bypass from decode straight to the head outputs.
module gppcu_issue_queue #(
  parameter int NUMREG = 32,
  parameter int DEPTH  = 4,
  parameter int IW     = 32,
  localparam int RBW   = $clog2(NUMREG),
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic           iACLK,
  input  logic           inRST,
  input  logic           iFLUSH,
  input  logic           iINSTR_VALID,
  output logic           oINSTR_READY,
  input  logic [IW-1:0]  iINSTR,
  input  logic [RBW-1:0] iREGD,
  input  logic [RBW-1:0] iREGA,
  input  logic [RBW-1:0] iREGB,
  input  logic           iVALID_REGD,
  input  logic           iVALID_REGA,
  input  logic           iVALID_REGB,
  output logic [RBW-1:0] oREGD,
  output logic [RBW-1:0] oREGA,
  output logic [RBW-1:0] oREGB,
  output logic           oVALID_REGD,
  output logic           oVALID_REGA,
  output logic           oVALID_REGB,
  input  logic           iENABLED,
  input  logic           iEXEC_READY,
  output logic           oISSUE,
  output logic [IW-1:0]  oISSUE_INSTR,
  output logic [CW-1:0]  oCOUNT,
  output logic           oEMPTY,
  output logic           oFULL
);
  localparam int AW = CW - 1;

  logic [IW-1:0]    pay_mem  [DEPTH];
  logic [RBW-1:0]   regd_mem [DEPTH];
  logic [RBW-1:0]   rega_mem [DEPTH];
  logic [RBW-1:0]   regb_mem [DEPTH];
  logic [DEPTH-1:0] vd_mem, va_mem, vb_mem;

  logic [AW-1:0] wp, rp;
  logic [CW-1:0] count;
  logic empty, full, push, pop;
  logic present, bypass, go, hv_d, hv_a, hv_b;

  assign empty        = (count == '0);
  assign full         = (count == CW'(DEPTH));
  assign oCOUNT       = count;
  assign oEMPTY       = empty;
  assign oFULL        = full;
  assign oINSTR_READY = ~full;

  // Head presentation; register valids are only exposed when the head could actually leave.
  always_comb begin
    present      = ~empty;
    bypass       = 1'b0;
    oREGD        = empty ? '0 : regd_mem[rp];
    oREGA        = empty ? '0 : rega_mem[rp];
    oREGB        = empty ? '0 : regb_mem[rp];
    oISSUE_INSTR = empty ? '0 : pay_mem[rp];
    hv_d         = ~empty & vd_mem[rp];
    hv_a         = ~empty & va_mem[rp];
    hv_b         = ~empty & vb_mem[rp];
`ifdef GPPCU_ISSUE_BYPASS_EN
    if (empty & iINSTR_VALID & ~iFLUSH) begin
      bypass       = 1'b1;
      present      = 1'b1;
      oREGD        = iREGD;
      oREGA        = iREGA;
      oREGB        = iREGB;
      oISSUE_INSTR = iINSTR;
      hv_d         = iVALID_REGD;
      hv_a         = iVALID_REGA;
      hv_b         = iVALID_REGB;
    end
`endif
    go          = present & iEXEC_READY & ~iFLUSH;
    oVALID_REGD = go & hv_d;
    oVALID_REGA = go & hv_a;
    oVALID_REGB = go & hv_b;
    oISSUE      = go & iENABLED;
    pop         = oISSUE & ~bypass;
    // A bypassed instruction that issues immediately is never stored.
    push        = iINSTR_VALID & ~full & ~iFLUSH & ~(bypass & oISSUE);
  end

  always_ff @(posedge iACLK) begin
    if (push) begin
      pay_mem[wp]  <= iINSTR;
      regd_mem[wp] <= iREGD;
      rega_mem[wp] <= iREGA;
      regb_mem[wp] <= iREGB;
      vd_mem[wp]   <= iVALID_REGD;
      va_mem[wp]   <= iVALID_REGA;
      vb_mem[wp]   <= iVALID_REGB;
    end
  end

  always_ff @(posedge iACLK or negedge inRST) begin
    if (!inRST) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else if (iFLUSH) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop)  rp <= rp + AW'(1);
      if (push & ~pop)      count <= count + CW'(1);
      else if (pop & ~push) count <= count - CW'(1);
    end
  end
endmodule

// File: tb/tb_gppcu_issue_queue.sv
// Self-checking bench for gppcu_issue_queue: directed scenarios plus random traffic against a queue model.
module tb_gppcu_issue_queue;
  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0, ivalid = 1'b0, enabled = 1'b0, exec_ready = 1'b0;
  logic [31:0] instr = '0;
  logic [4:0]  regd = '0, rega = '0, regb = '0;
  logic        vd = 1'b0, va = 1'b0, vb = 1'b0;
  logic        ready, ovd, ova, ovb, issue, empty, full;
  logic [4:0]  oregd, orega, oregb;
  logic [31:0] issue_instr;
  logic [2:0]  count;

  always #5 clk = ~clk;

  gppcu_issue_queue #(.NUMREG(32), .DEPTH(DEPTH), .IW(32)) dut (
    .iACLK(clk), .inRST(rst_n), .iFLUSH(flush),
    .iINSTR_VALID(ivalid), .oINSTR_READY(ready), .iINSTR(instr),
    .iREGD(regd), .iREGA(rega), .iREGB(regb),
    .iVALID_REGD(vd), .iVALID_REGA(va), .iVALID_REGB(vb),
    .oREGD(oregd), .oREGA(orega), .oREGB(oregb),
    .oVALID_REGD(ovd), .oVALID_REGA(ova), .oVALID_REGB(ovb),
    .iENABLED(enabled), .iEXEC_READY(exec_ready),
    .oISSUE(issue), .oISSUE_INSTR(issue_instr),
    .oCOUNT(count), .oEMPTY(empty), .oFULL(full)
  );

  typedef struct {
    logic [31:0] pay;
    logic [4:0]  d, a, b;
    logic        vd, va, vb;
  } ent_t;

  ent_t q[$];
  int   n_cmp = 0, n_bad = 0;
  bit   done = 1'b0;

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  // Monitor / scoreboard: checks outputs mid-cycle and pops expected payloads on each issue.
  always @(negedge clk) begin
    if (!done) begin
      if (!rst_n) begin
        q.delete();
        chk("rst_empty", empty, 1); chk("rst_full", full, 0);
        chk("rst_ready", ready, 1); chk("rst_count", count, 0);
        chk("rst_issue", issue, 0); chk("rst_vd", ovd, 0);
        chk("rst_va", ova, 0);      chk("rst_vb", ovb, 0);
        chk("rst_regd", oregd, 0);
      end else begin
        int   sz;
        bit   has_head, byp, src_ok, e_issue, acc;
        ent_t h, inp;
        sz  = q.size();
        inp = '{pay: instr, d: regd, a: rega, b: regb, vd: vd, va: va, vb: vb};
        has_head = (sz > 0);
        byp = 1'b0;
`ifdef GPPCU_ISSUE_BYPASS_EN
        byp = (sz == 0) && ivalid && !flush;
`endif
        if (has_head)  h = q[0];
        else if (byp)  h = inp;
        else           h = '{pay: 0, d: 0, a: 0, b: 0, vd: 0, va: 0, vb: 0};
        src_ok  = (has_head || byp) && exec_ready && !flush;
        e_issue = src_ok && enabled;

        chk("count", count, sz);
        chk("empty", empty, sz == 0);
        chk("full", full, sz == DEPTH);
        chk("ready", ready, sz < DEPTH);
        chk("regd", oregd, h.d);
        chk("rega", orega, h.a);
        chk("regb", oregb, h.b);
        chk("valid_regd", ovd, src_ok && h.vd);
        chk("valid_rega", ova, src_ok && h.va);
        chk("valid_regb", ovb, src_ok && h.vb);
        chk("issue", issue, e_issue);
        if (e_issue) chk("issue_instr", issue_instr, h.pay);

        if (flush) q.delete();
        else begin
          if (e_issue && has_head) void'(q.pop_front());
          acc = ivalid && (sz < DEPTH);
          if (acc && !(byp && e_issue)) q.push_back(inp);
        end
      end
    end
  end

  task automatic cyc(bit v, bit en, bit ex, bit fl, int fixed_d = -1);
    ivalid = v; enabled = en; exec_ready = ex; flush = fl;
    instr = $urandom;
    regd = (fixed_d >= 0) ? 5'(fixed_d) : 5'($urandom_range(0, 31));
    rega = 5'($urandom_range(0, 31));
    regb = 5'($urandom_range(0, 31));
    vd = (fixed_d >= 0) ? 1'b1 : 1'($urandom_range(0, 1));
    va = 1'($urandom_range(0, 1));
    vb = 1'($urandom_range(0, 1));
    @(posedge clk); #1;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (2) cyc(0, 0, 0, 0);
    // Fill to full with issue blocked; fifth offer must be refused, then drain in order.
    repeat (5) cyc(1, 0, 1, 0);
    repeat (5) cyc(0, 1, 1, 0);
    // Hazard-free head held back by execute stage, then released.
    cyc(1, 1, 0, 0, 5);
    repeat (2) cyc(0, 1, 0, 0);
    cyc(0, 1, 1, 0);
    // Steady stream at count 2 across pointer wrap.
    repeat (2) cyc(1, 0, 1, 0);
    repeat (10) cyc(1, 1, 1, 0);
    repeat (3) cyc(0, 1, 1, 0);
    // Flush with three queued and a simultaneous push.
    repeat (3) cyc(1, 0, 1, 0);
    cyc(1, 1, 1, 1);
    repeat (3) cyc(0, 1, 1, 0);
    // Empty queue, push with issue permitted.
    cyc(1, 1, 1, 0);
    repeat (2) cyc(0, 1, 1, 0);
    // Random traffic.
    for (int i = 0; i < 2000; i++)
      cyc($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
          $urandom_range(0, 3) != 0, $urandom_range(0, 31) == 0);
    cyc(0, 0, 0, 0);
    done = 1'b1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
